// File: rtl/seq_mult_ctrl_if.sv
// seq_mult_ctrl_if: operand/result handshake bundle for seq_mult_ctrl.
//   Start       issuer -> multiplier  request a multiply (honoured only when idle)
//   Signed_mode issuer -> multiplier  1 = two's-complement operands
//   Xin, Y      issuer -> multiplier  multiplicand / multiplier, WIDTH bits
//   Busy        multiplier -> issuer  high while an operation is in flight
//   Done        multiplier -> issuer  one-cycle pulse when M is valid
//   M           multiplier -> issuer  2*WIDTH-bit product register
interface seq_mult_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                 Start;
    logic                 Signed_mode;
    logic [WIDTH-1:0]     Xin;
    logic [WIDTH-1:0]     Y;
    logic                 Busy;
    logic                 Done;
    logic [2*WIDTH-1:0]   M;

    modport master (
        output Start, Signed_mode, Xin, Y,
        input  Busy, Done, M
    );

    modport slave (
        input  Start, Signed_mode, Xin, Y,
        output Busy, Done, M
    );
endinterface

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: sequential shift-and-add multiplier, WIDTH-bit operands,
// 2*WIDTH-bit product, signed or unsigned per operation, with early exit
// once the remaining multiplier bits are all zero.
//   Clk     rising-edge clock
//   Resetn  synchronous active-low reset; aborts any operation in flight
//   bus     seq_mult_ctrl_if slave: Start/Signed_mode/Xin/Y in,
//           Busy/Done/M out (all outputs decoded from registers only)
module seq_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic          Clk,
    input  logic          Resetn,
    seq_mult_ctrl_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   mag_x, mag_x_nx;
    logic [PW-1:0]   acc, acc_nx;
    logic [PW-1:0]   m_reg, m_nx;
    logic [WIDTH-1:0] mag_y, mag_y_nx;
    logic            neg, neg_nx;
    logic [CW-1:0]   cnt, cnt_nx;

    logic [WIDTH-1:0] x_abs, y_abs;
    logic [PW-1:0]   sum;
    logic [WIDTH-1:0] y_shift;
    logic [CW-1:0]   cnt_inc;

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state <= IDLE;
            mag_x <= '0;
            mag_y <= '0;
            acc   <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
            m_reg <= '0;
        end else begin
            state <= state_nx;
            mag_x <= mag_x_nx;
            mag_y <= mag_y_nx;
            acc   <= acc_nx;
            neg   <= neg_nx;
            cnt   <= cnt_nx;
            m_reg <= m_nx;
        end
    end

    always_comb begin
        state_nx = state;
        mag_x_nx = mag_x;
        mag_y_nx = mag_y;
        acc_nx   = acc;
        neg_nx   = neg;
        cnt_nx   = cnt;
        m_nx     = m_reg;

        // Magnitudes as WIDTH-bit unsigned; the most negative value maps
        // onto 2^(WIDTH-1), which still fits.
        x_abs = (bus.Signed_mode && bus.Xin[WIDTH-1]) ? -bus.Xin : bus.Xin;
        y_abs = (bus.Signed_mode && bus.Y[WIDTH-1])   ? -bus.Y   : bus.Y;

        sum     = mag_y[0] ? (acc + mag_x) : acc;
        y_shift = mag_y >> 1;
        cnt_inc = cnt + CW'(1);

        case (state)
            IDLE: begin
                if (bus.Start) begin
                    mag_x_nx = {{WIDTH{1'b0}}, x_abs};
                    mag_y_nx = y_abs;
                    neg_nx   = bus.Signed_mode & (bus.Xin[WIDTH-1] ^ bus.Y[WIDTH-1]);
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                acc_nx   = sum;
                mag_x_nx = mag_x << 1;
                mag_y_nx = y_shift;
                cnt_nx   = cnt_inc;
                // The result is taken from this step's sum so M only ever
                // sees a finished product.
                if ((y_shift == '0) || (cnt_inc == STEP_LAST)) begin
                    m_nx     = neg ? -sum : sum;
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.Busy = (state != IDLE);
    assign bus.Done = (state == DONE);
    assign bus.M    = m_reg;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl: directed checks of seq_mult_ctrl at WIDTH=8 and an
// exhaustive operand sweep at WIDTH=4 against an arithmetic reference.
module tb_seq_mult_ctrl;
    logic Clk = 1'b0;
    logic Resetn;
    always #5 Clk = ~Clk;

    seq_mult_ctrl_if #(.WIDTH(8)) bus8 ();
    seq_mult_ctrl_if #(.WIDTH(4)) bus4 ();

    seq_mult_ctrl #(.WIDTH(8)) dut8 (
        .Clk    (Clk),
        .Resetn (Resetn),
        .bus    (bus8)
    );

    seq_mult_ctrl #(.WIDTH(4)) dut4 (
        .Clk    (Clk),
        .Resetn (Resetn),
        .bus    (bus4)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One complete WIDTH=8 operation: capture, bounded wait for Done,
    // latency/product/pulse-width checks.
    task automatic run8(input string tag, input logic sm, input logic [7:0] x,
                        input logic [7:0] y, input logic [15:0] expm, input int steps);
        int cyc;
        bus8.Start       = 1'b1;
        bus8.Signed_mode = sm;
        bus8.Xin         = x;
        bus8.Y           = y;
        tick();
        bus8.Start       = 1'b0;
        bus8.Signed_mode = 1'($urandom);
        bus8.Xin         = 8'($urandom);
        bus8.Y           = 8'($urandom);
        cyc = 1;
        check({tag, "_busy"}, 32'(bus8.Busy), 32'd1);
        while (!bus8.Done && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(steps + 1));
        check({tag, "_M"}, 32'(bus8.M), 32'(expm));
        tick();
        check({tag, "_done_low"}, 32'(bus8.Done), 32'd0);
        check({tag, "_idle"}, 32'(bus8.Busy), 32'd0);
    endtask

    task automatic run4(input logic sm, input logic [3:0] x, input logic [3:0] y);
        int sx, sy, p, ay, steps, cyc;
        logic [7:0] expm;
        string tag;
        tag = $sformatf("w4_s%0d_x%0d_y%0d", sm, x, y);
        sx = sm ? int'($signed(x)) : int'(x);
        sy = sm ? int'($signed(y)) : int'(y);
        p = sx * sy;
        expm = p[7:0];
        ay = (sy < 0) ? -sy : sy;
        steps = 1;
        for (int k = 0; k < 4; k++) if (ay[k]) steps = k + 1;

        bus4.Start       = 1'b1;
        bus4.Signed_mode = sm;
        bus4.Xin         = x;
        bus4.Y           = y;
        tick();
        bus4.Start = 1'b0;
        bus4.Xin   = 4'($urandom);
        bus4.Y     = 4'($urandom);
        cyc = 1;
        while (!bus4.Done && cyc < 12) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(steps + 1));
        check({tag, "_M"}, 32'(bus4.M), 32'(expm));
        tick();
        check({tag, "_done_low"}, 32'(bus4.Done), 32'd0);
    endtask

    initial begin
        int cyc;
        int dones;
        logic [15:0] mseen;

        Resetn = 1'b0;
        bus8.Start = 1'b0; bus8.Signed_mode = 1'b0; bus8.Xin = '0; bus8.Y = '0;
        bus4.Start = 1'b0; bus4.Signed_mode = 1'b0; bus4.Xin = '0; bus4.Y = '0;
        tick();
        tick();
        check("rst_busy", 32'(bus8.Busy), 32'd0);
        check("rst_done", 32'(bus8.Done), 32'd0);
        check("rst_M", 32'(bus8.M), 32'd0);
        check("rst4_busy", 32'(bus4.Busy), 32'd0);
        check("rst4_M", 32'(bus4.M), 32'd0);
        Resetn = 1'b1;
        tick();

        run8("u255x255", 1'b0, 8'd255, 8'd255, 16'hFE01, 8);
        run8("u200x3",   1'b0, 8'd200, 8'd3,   16'd600,  2);
        run8("u200x0",   1'b0, 8'd200, 8'd0,   16'd0,    1);
        run8("s-3x5",    1'b1, 8'hFD,  8'd5,   16'hFFF1, 3);
        run8("s-128sq",  1'b1, 8'h80,  8'h80,  16'h4000, 8);
        run8("s127x-1",  1'b1, 8'd127, 8'hFF,  16'hFF81, 1);

        // Start held high through RUN and DONE with other operands present.
        bus8.Start = 1'b1; bus8.Signed_mode = 1'b0; bus8.Xin = 8'd7; bus8.Y = 8'd9;
        tick();
        bus8.Xin = 8'd3; bus8.Y = 8'd4;
        cyc = 1; dones = 0; mseen = '0;
        while (bus8.Busy && cyc < 20) begin
            if (bus8.Done) begin
                dones++;
                mseen = bus8.M;
            end
            tick();
            cyc++;
        end
        check("hs_dones", 32'(dones), 32'd1);
        check("hs_M", 32'(mseen), 32'd63);
        check("hs_gap_busy", 32'(bus8.Busy), 32'd0);
        check("hs_gap_cycle", 32'(cyc), 32'd6);
        tick();
        check("hs_recapture", 32'(bus8.Busy), 32'd1);
        bus8.Start = 1'b0;
        cyc = 1;
        while (!bus8.Done && cyc < 20) begin
            tick();
            cyc++;
        end
        check("hs2_lat", 32'(cyc), 32'd4);
        check("hs2_M", 32'(bus8.M), 32'd12);
        tick();

        // Reset arriving on the edge of step 4 of a long operation.
        bus8.Start = 1'b1; bus8.Signed_mode = 1'b0; bus8.Xin = 8'd255; bus8.Y = 8'd255;
        tick();
        bus8.Start = 1'b0;
        tick(); tick(); tick();
        check("ab_busy_pre", 32'(bus8.Busy), 32'd1);
        Resetn = 1'b0;
        tick();
        check("ab_busy", 32'(bus8.Busy), 32'd0);
        check("ab_done", 32'(bus8.Done), 32'd0);
        check("ab_M", 32'(bus8.M), 32'd0);
        Resetn = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus8.Done) dones++;
        end
        check("ab_no_done", 32'(dones), 32'd0);
        check("ab_M_hold", 32'(bus8.M), 32'd0);
        run8("u12x12", 1'b0, 8'd12, 8'd12, 16'd144, 4);

        for (int m = 0; m < 2; m++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    run4(1'(m), 4'(a), 4'(b));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_mult_ctrl.md
# seq_mult_ctrl

Parametrised sequential shift-and-add multiplier for the arithmetic datapath. It generalises the fixed 4-bit multiplier to WIDTH-bit operands and adds a Start/Busy/Done handshake, a per-operation signed/unsigned mode and early termination when the remaining multiplier bits are zero. It sits between an operand-issuing controller and any consumer that samples the product on Done.

## Interface
- WIDTH, default 8: operand width in bits, ≥ 2. The product is 2*WIDTH bits.
- Clk  in  1  clock; all state changes on the rising edge.
- Resetn  in  1  reset, synchronous, active-low.
- Start  in  1  request a multiply; sampled only in IDLE.
- Signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with Start.
- Xin  in  WIDTH  multiplicand; sampled with Start.
- Y  in  WIDTH  multiplier; sampled with Start.
- Busy  out  1  high whenever the state is not IDLE.
- Done  out  1  single-cycle pulse; M is valid from this cycle onward.
- M  out  2*WIDTH  product register.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE; Busy=0, Done=0, M=0, internal registers cleared.
- IDLE: if Start=1 at an edge, capture operands and go to RUN. Otherwise stay.
  - Unsigned: mag_x = Xin zero-extended to 2*WIDTH; mag_y = Y; neg = 0.
  - Signed: mag_x = |Xin| and mag_y = |Y|, each as a WIDTH-bit unsigned value (|−2^(WIDTH−1)| = 2^(WIDTH−1) fits); neg = Xin[MSB] XOR Y[MSB].
  - acc = 0; step counter = 0.
- RUN, one step per edge: if mag_y[0] then acc += mag_x; mag_x <<= 1; mag_y >>= 1; counter += 1.
- Step count: leave RUN after the step where shifted mag_y becomes 0 or counter reaches WIDTH, whichever comes first. The step count equals the bit length of mag_y, with a minimum of 1 when mag_y = 0.
- On the edge that leaves RUN, load M with the final acc, or with −acc (two's complement, 2*WIDTH bits) when neg=1. Go to DONE.
- DONE: Done=1 for exactly one cycle, Busy=1. The next edge returns to IDLE unconditionally.
- M holds its value until the next result is loaded. It is never partially updated during RUN.
- Start while Busy=1, including in DONE, is ignored and not queued. Operand inputs are don't-care outside the capture edge.
- Arithmetic: acc is 2*WIDTH bits wide. An unsigned product is at most (2^WIDTH−1)^2 and never overflows. The signed product range [−2^(2W−2)+2^(W−1), 2^(2W−2)] fits in 2*WIDTH signed bits.
- Resetn=0 during RUN or DONE aborts the operation: IDLE, M=0, no Done pulse.

## Timing
- Edge 0 samples Start=1 and enters RUN, so Busy=1 from cycle 1.
- Edges 1…S perform the S steps, where 1 ≤ S ≤ WIDTH. Edge S loads M and enters DONE.
- Done=1 in the cycle after edge S. Edge S+1 returns to IDLE, with Busy=0 and Done=0.
- Latency from Start sampling to Done is S+1 cycles, at most WIDTH+1.
- A new Start is accepted at edge S+2 at the earliest, so back-to-back throughput is one product per S+2 cycles.
- Start, Xin, Y and Signed_mode have setup to the capture edge only. No combinational path exists from any input to any output.

## Test plan
- WIDTH=8, unsigned, Xin=255, Y=255: S=8. Done is asserted 9 cycles after Start, with M=16'hFE01 (65025).
- WIDTH=8, unsigned, Xin=200, Y=3: early termination with S=2. Done is asserted 3 cycles after Start, M=600. Repeat with Y=0: S=1, M=0, Done after 2 cycles.
- WIDTH=8, signed:
  - Xin=−3 (8'hFD), Y=5 gives M=16'hFFF1 (−15), S=3.
  - Xin=−128, Y=−128 gives M=16'h4000 (16384), S=8.
  - Xin=127, Y=−1 gives M=16'hFF81 (−127), S=1.
- Handshake: issue Start with 7×9 and hold Start=1 through RUN and DONE with different operands. Exactly one Done pulse occurs, with M=63. Busy drops for a cycle, then a new capture takes the held operands.
- Reset mid-operation: start 255×255, assert Resetn=0 at step 4. On the next edge, Busy=0, M=0, and no Done pulse follows. A subsequent 12×12 gives M=144.
- WIDTH=4 instance: run an exhaustive unsigned and signed sweep of all 256 operand pairs against a reference model. Check M, check S equals the bit length of |Y| (minimum 1), and check that Done is a single cycle.
